prog_mem: RTL

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_mem_pkg.sv | 28 ++
 rtl/prog_mem_ram.sv | 23 ++
 rtl/prog_mem.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory: loader FSM states,
// default geometry and instruction-word field offsets.
package prog_mem_pkg;

  localparam int PM_DATA_W = 15;
  localparam int PM_ADDR_W = 8;

  localparam int OP_LSB = 10;
  localparam int OP_W   = 5;
  localparam int SR_LSB = 7;
  localparam int SR_W   = 3;
  localparam int LR_LSB = 4;
  localparam int LR_W   = 3;
  localparam int IM_LSB = 0;
  localparam int IM_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_DONE
  } pm_state_t;

  function automatic logic [OP_W-1:0] op_field(input logic [PM_DATA_W-1:0] word);
    return word[OP_LSB +: OP_W];
  endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// Single-port synchronous RAM, write-first; read data registered when re is high.
// One-cycle read latency, no backpressure.
module prog_mem_ram #(
  parameter int DATA_W = 15,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= we ? wdata : mem[addr];
  end

endmodule

// File: rtl/prog_mem.sv
// Program memory with CPU strobe port, streaming loader and zero-fill engine.
// CPU reads return one cycle after nOE low; CPU writes are dropped while the loader/clear runs.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = PM_DATA_W,
  parameter int ADDR_W = PM_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PA,
  input  logic              nOE,
  input  logic              nWE,
  input  logic [DATA_W-1:0] D_IN,
  output logic [DATA_W-1:0] D_OUT,
  output logic              D_OE,
  input  logic              LD_START,
  input  logic [ADDR_W:0]   LD_LEN,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_READY,
  output logic              LD_DONE,
  input  logic              CLR,
  output logic              BUSY,
  output logic              WR_DROP
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  pm_state_t         state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len;
  logic              prev_nwe;
  logic              rd_zero;
  logic              cpu_wr;
  logic              pa_ok;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign pa_ok  = {1'b0, PA} < DEPTH_C;
  assign cpu_wr = prev_nwe & ~nWE;

  // Loader and clear own the RAM port while active; CPU writes only reach it otherwise.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = PA;
    ram_wdata = D_IN;
    case (state)
      ST_LOAD: begin
        ram_we    = LD_VALID;
        ram_addr  = cnt[ADDR_W-1:0];
        ram_wdata = LD_DATA;
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = cnt[ADDR_W-1:0];
        ram_wdata = '0;
      end
      default: ram_we = cpu_wr & pa_ok;
    endcase
  end

  prog_mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .re    (~nOE),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // rd_zero is captured alongside the RAM read, so masking stays aligned with the data.
  assign D_OUT = rd_zero ? '0 : ram_rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      len      <= '0;
      D_OE     <= 1'b0;
      LD_READY <= 1'b0;
      LD_DONE  <= 1'b0;
      BUSY     <= 1'b0;
      WR_DROP  <= 1'b0;
      prev_nwe <= 1'b1;
      rd_zero  <= 1'b1;
    end else begin
      prev_nwe <= nWE;
      D_OE     <= ~nOE;
      LD_DONE  <= 1'b0;
      if (~nOE) rd_zero <= BUSY | ~pa_ok;
      if (cpu_wr && BUSY) WR_DROP <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (CLR) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end else if (LD_START) begin
            if (LD_LEN == '0 || LD_LEN > DEPTH_C) begin
              LD_DONE <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              cnt      <= '0;
              len      <= LD_LEN;
              BUSY     <= 1'b1;
              LD_READY <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (LD_VALID) begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == len) begin
              state    <= ST_DONE;
              BUSY     <= 1'b0;
              LD_READY <= 1'b0;
              LD_DONE  <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == DEPTH_C - 1'b1) begin
            state   <= ST_DONE;
            BUSY    <= 1'b0;
            LD_DONE <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
